// File: rtl/sipo_frame.sv
// Serial-in/parallel-out deserialiser: collects WIDTH qualified bits, then holds the
// assembled word on po under a valid/ready handshake with sticky overrun detection.
module sipo_frame #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         si,
   input  logic                         si_en,
   input  logic                         flush,
   input  logic                         po_ready,
   output logic [WIDTH-1:0]             po,
   output logic                         po_valid,
   output logic                         overrun,
   output logic                         so,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

   localparam int CW = $clog2(WIDTH+1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic             shift;
   logic             last_bit;
   logic             complete;
   logic             xfer;

   always_comb begin
      sr_next  = LSB_FIRST ? {si, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], si};
      shift    = si_en & ~flush;
      last_bit = (bit_cnt == CW'(WIDTH-1));
      complete = shift & last_bit;
      xfer     = po_valid & po_ready;
   end

   assign so = LSB_FIRST ? sr[0] : sr[WIDTH-1];

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values; blocking would let sr_next/bit_cnt race within the edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sr       <= '0;
         bit_cnt  <= '0;
         po       <= '0;
         po_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (flush) begin
            sr      <= '0;
            bit_cnt <= '0;
         end else if (si_en) begin
            sr      <= sr_next;
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
         end

         // A completing frame wins over a transfer; it only counts as overrun
         // when the pending word was not accepted in this same cycle.
         if (complete) begin
            po       <= sr_next;
            po_valid <= 1'b1;
            if (po_valid && !po_ready)
               overrun <= 1'b1;
         end else if (xfer) begin
            po_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_frame.sv
// Directed bench for sipo_frame: bit order, gaps, flush, backpressure/overrun,
// simultaneous completion+transfer and asynchronous reset, on 4- and 8-bit builds.
module tb_sipo_frame;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       si = 1'b0, si_en = 1'b0, flush = 1'b0, po_ready = 1'b0;
   logic       si2 = 1'b0, si2_en = 1'b0;

   logic [3:0] po_a, po_b;
   logic       valid_a, valid_b, ovr_a, ovr_b, so_a, so_b;
   logic [2:0] cnt_a, cnt_b;
   logic [7:0] po_c;
   logic       valid_c, ovr_c, so_c;
   logic [3:0] cnt_c;

   int tests = 0;
   int fails = 0;

   sipo_frame #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb4 (
      .clk(clk), .clr(clr), .si(si), .si_en(si_en), .flush(flush), .po_ready(po_ready),
      .po(po_a), .po_valid(valid_a), .overrun(ovr_a), .so(so_a), .bit_cnt(cnt_a));

   sipo_frame #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb4 (
      .clk(clk), .clr(clr), .si(si), .si_en(si_en), .flush(flush), .po_ready(po_ready),
      .po(po_b), .po_valid(valid_b), .overrun(ovr_b), .so(so_b), .bit_cnt(cnt_b));

   sipo_frame #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb8 (
      .clk(clk), .clr(clr), .si(si2), .si_en(si2_en), .flush(1'b0), .po_ready(1'b1),
      .po(po_c), .po_valid(valid_c), .overrun(ovr_c), .so(so_c), .bit_cnt(cnt_c));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      si = b;
      si_en = 1'b1;
      tick();
      si_en = 1'b0;
   endtask

   task automatic send8(input logic b);
      si2 = b;
      si2_en = 1'b1;
      tick();
      si2_en = 1'b0;
   endtask

   initial begin
      logic [3:0] v1011;
      logic [7:0] a5;
      v1011 = 4'b1011;
      a5    = 8'hA5;

      // Reset held for two edges
      tick();
      check("rst_po", po_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_overrun", ovr_a, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_so", so_a, 0);
      tick();
      clr = 1'b0;

      // 1,0,1,1 MSB-first and LSB-first, po_ready high
      po_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(v1011[3-i]);
         check($sformatf("cnt_step%0d", i), cnt_a, (i + 1) % 4);
         check($sformatf("valid_step%0d", i), valid_a, (i == 3) ? 1 : 0);
      end
      check("msb4_po", po_a, 4'b1011);
      check("lsb4_po", po_b, 4'b1101);
      tick();
      check("valid_pulse_end", valid_a, 0);
      check("po_held", po_a, 4'b1011);

      // 8-bit, 0xA5 MSB first, watching so at sr[7]
      for (int i = 0; i < 8; i++) send8(a5[7-i]);
      check("msb8_po", po_c, 8'hA5);
      check("msb8_valid", valid_c, 1);
      check("msb8_so_after8", so_c, 1);
      send8(1'b0);
      check("msb8_so_after9", so_c, 0);
      check("msb8_valid_fall", valid_c, 0);
      send8(1'b0);
      check("msb8_so_after10", so_c, 1);
      check("msb8_cnt", cnt_c, 2);

      // Gapped input then flush
      send(1'b1);
      send(1'b1);
      check("gap_cnt2", cnt_a, 2);
      check("gap_so_before", so_a, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("gap_hold%0d", i), cnt_a, 2);
      end
      flush = 1'b1;
      send(1'b1);
      flush = 1'b0;
      check("flush_cnt", cnt_a, 0);
      check("flush_so", so_a, 0);
      check("flush_po", po_a, 4'b1011);
      send(1'b0); send(1'b1); send(1'b1); send(1'b0);
      check("post_flush_po", po_a, 4'b0110);
      check("post_flush_valid", valid_a, 1);
      tick();

      // Backpressure and overrun
      po_ready = 1'b0;
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
      check("bp_po1", po_a, 4'b1001);
      check("bp_valid1", valid_a, 1);
      check("bp_ovr_none", ovr_a, 0);
      send(1'b0); send(1'b1); send(1'b1);
      check("bp_valid_mid", valid_a, 1);
      send(1'b1);
      check("bp_po2", po_a, 4'b0111);
      check("bp_valid2", valid_a, 1);
      check("bp_overrun", ovr_a, 1);
      po_ready = 1'b1;
      tick();
      po_ready = 1'b0;
      check("bp_valid_fall", valid_a, 0);
      check("bp_overrun_sticky", ovr_a, 1);

      // Asynchronous reset mid-frame
      send(1'b1); send(1'b0);
      check("pre_clr_cnt", cnt_a, 2);
      #2 clr = 1'b1;
      #1;
      check("aclr_po", po_a, 0);
      check("aclr_cnt", cnt_a, 0);
      check("aclr_overrun", ovr_a, 0);
      check("aclr_valid", valid_a, 0);
      tick();
      clr = 1'b0;
      send(1'b0); send(1'b0); send(1'b1); send(1'b1);
      check("post_clr_po", po_a, 4'b0011);
      check("post_clr_valid", valid_a, 1);

      // Completion in the same cycle as a transfer
      send(1'b1); send(1'b0); send(1'b1);
      check("sim_pending", valid_a, 1);
      po_ready = 1'b1;
      send(1'b0);
      check("sim_po", po_a, 4'b1010);
      check("sim_valid", valid_a, 1);
      check("sim_overrun", ovr_a, 0);
      tick();
      check("sim_valid_fall", valid_a, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sipo_frame.md
# sipo_frame

Parameterised serial-in/parallel-out deserialiser with bit counting, a double-buffered parallel output and a valid/ready handshake. It collects `WIDTH` serial bits, one per qualified clock, then presents the assembled word on a held output register. It sits between a serial bit source (a UART or SPI front end, or a test stimulus) and word-oriented logic. It is the successor to the team's fixed 4-bit SIPO: configurable width and bit order, a frame boundary, abort, overrun detection, and a cascade output.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..32.
- `LSB_FIRST`, default 0: 0 = first received bit lands in `po[WIDTH-1]`; 1 = first received bit lands in `po[0]`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `clr` input 1: reset, asynchronous, active-high.
- `si` input 1: serial data bit.
- `si_en` input 1: qualifies `si`; a bit is shifted only in cycles with `si_en`=1.
- `flush` input 1: synchronous abort of the partial frame.
- `po_ready` input 1: consumer accepts the word on `po`.
- `po` output WIDTH: last completed word, held.
- `po_valid` output 1: `po` holds an unconsumed word.
- `overrun` output 1: sticky; a completed word was overwritten before it was accepted.
- `so` output 1: bit about to leave the shift register, for cascading.
- `bit_cnt` output clog2(WIDTH+1): number of bits in the current partial frame.

## Operation
- Internal shift register `sr[WIDTH-1:0]` and counter `bit_cnt`.
- Shift direction:
  - `LSB_FIRST`=0: next `sr` = {sr[WIDTH-2:0], si}.
  - `LSB_FIRST`=1: next `sr` = {si, sr[WIDTH-1:1]}.
- `so` = sr[WIDTH-1] when `LSB_FIRST`=0; `so` = sr[0] when `LSB_FIRST`=1. It is combinational from `sr`.
- Shift step, on a cycle with `si_en`=1 and `flush`=0:
  - `sr` shifts.
  - If `bit_cnt` < WIDTH-1, `bit_cnt` increments.
  - If `bit_cnt` == WIDTH-1, the frame completes: `po` <= next `sr`, which includes the current bit; `bit_cnt` <= 0; `po_valid` <= 1.
- Output handshake:
  - The word transfers in any cycle where `po_valid`=1 and `po_ready`=1.
  - After a transfer, `po_valid` clears on the next edge unless a frame completes in that same cycle.
  - `po_ready` is ignored while `po_valid`=0.
- Overrun: a frame completes while `po_valid`=1 and `po_ready`=0.
  - `po` is overwritten with the new word and `po_valid` stays 1.
  - `overrun` sets to 1 and holds until `clr`.
- Simultaneous completion and transfer (`po_valid`=1, `po_ready`=1, frame completing): the old word is consumed, `po` loads the new word, `po_valid` stays 1, and `overrun` is not set.
- Flush: `flush`=1 sets `bit_cnt` <= 0 and `sr` <= 0.
  - Flush has priority over `si_en`; the bit in that cycle is dropped.
  - `po`, `po_valid` and `overrun` are unaffected.
  - A transfer may still occur in the same cycle.
- `si_en`=0 holds `sr` and `bit_cnt`. Idle gaps between bits of a frame are allowed.

## Timing
- Reset (`clr`=1, asynchronous, immediate): `sr`=0, `po`=0, `po_valid`=0, `overrun`=0, `bit_cnt`=0, `so`=0.
- Outputs remain at reset values while `clr` is held. The first shift can occur on the first rising edge after `clr` deasserts.
- `clr` asserted mid-frame discards the partial frame and any pending word.
- Latency: `po` and `po_valid` update on the same rising edge that samples the WIDTH-th qualified bit. With continuous `si_en`, a new word is available every WIDTH cycles.
- `po_valid` falls on the edge after a transfer. With `po_ready` tied high it is a one-cycle pulse per word.
- `bit_cnt` wraps WIDTH-1 → 0 on completion and never reaches WIDTH.
- All outputs except `so` are registered; `so` is combinational from registered `sr`.

## Test plan
- Reset and bit order (WIDTH=4, LSB_FIRST=0): assert `clr` for 2 cycles, then send 1,0,1,1 with `si_en`=1 and `po_ready`=1. Required: `po`=4'b1011; `po_valid` high for exactly one cycle, on the edge sampling the 4th bit; `bit_cnt` steps 1,2,3,0.
- LSB_FIRST=1, WIDTH=4: send 1,0,1,1. Required: `po`=4'b1101. With WIDTH=8, LSB_FIRST=0, send 0xA5 MSB first. Required: `po`=8'hA5, and `so` shows bits shifting out of sr[7].
- Gapped input and flush: send 1,1, then `si_en`=0 for 3 cycles (`bit_cnt` holds at 2). Assert `flush` together with `si_en`=1. Required: `bit_cnt`=0, `sr`=0, and `po` unchanged. Then send 0,1,1,0. Required: `po`=4'b0110.
- Backpressure and overrun: hold `po_ready`=0 and send two frames, 1,0,0,1 then 0,1,1,1. Required: `po_valid`=1 throughout, `po`=4'b0111, `overrun`=1. Then raise `po_ready` for 1 cycle. Required: `po_valid` falls and `overrun` stays 1 until `clr`.
- Simultaneous events: complete a frame in the same cycle as `po_ready`=1 with a word pending. Required: new word loaded, `po_valid` stays 1, `overrun`=0.
- Asynchronous reset mid-frame: assert `clr` between clock edges after 2 bits. Required: all outputs clear immediately. After release, a fresh 4-bit frame 0,0,1,1 gives `po`=4'b0011.
